// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N   = 16;
  localparam int unsigned IDW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
    logic [N-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_16_if;
  import arb_pkg::*;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;

  modport master (output req, input gnt, input gnt_id, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid);

endinterface

// File: rtl/prio_enc_16x4.sv
// Lowest-index-first priority encoder: idx of the first set bit, any when one exists.
module prio_enc_16x4
  import arb_pkg::*;
(
  input  logic [N-1:0]   vec,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !any) begin
        idx = IDW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with registered one-hot/binary grant
// and an optional hold-time limit that only applies while others are waiting.
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
)(
  input  logic            clk,
  input  logic            rst,
  rr_arbiter_16_if.slave  bus
);

  localparam int unsigned    HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);

  arb_state_e     state_q;
  logic [IDW-1:0] ptr_q;
  logic [HCW-1:0] hold_q;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic           gnt_valid_q;

  logic [N-1:0]   cur_mask;
  logic [N-1:0]   ptr_mask;
  logic [N-1:0]   cand_all;
  logic [N-1:0]   cand_hi;
  logic [IDW-1:0] idx_hi;
  logic [IDW-1:0] idx_all;
  logic           any_hi;
  logic           any_all;
  logic [IDW-1:0] sel_idx;
  logic           released;
  logic           timeout;
  logic           grant_end;

  // The current owner is masked out so a pending handoff never re-selects it.
  always_comb begin
    cur_mask  = (state_q == GRANT) ? onehot(gnt_id_q) : '0;
    ptr_mask  = {N{1'b1}} << ptr_q;
    cand_all  = bus.req & ~cur_mask;
    cand_hi   = cand_all & ptr_mask;
    sel_idx   = any_hi ? idx_hi : idx_all;
    released  = !bus.req[gnt_id_q];
    timeout   = HOLD_EN && (hold_q == HOLD_LAST) && any_all;
    grant_end = released || timeout;
  end

  prio_enc_16x4 u_enc_hi (
    .vec (cand_hi),
    .idx (idx_hi),
    .any (any_hi)
  );

  prio_enc_16x4 u_enc_all (
    .vec (cand_all),
    .idx (idx_all),
    .any (any_all)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_all) begin
            state_q     <= GRANT;
            gnt_q       <= onehot(sel_idx);
            gnt_id_q    <= sel_idx;
            gnt_valid_q <= 1'b1;
            hold_q      <= '0;
          end
        end
        GRANT: begin
          if (grant_end) begin
            ptr_q <= gnt_id_q + 1'b1;
            if (any_all) begin
              gnt_q       <= onehot(sel_idx);
              gnt_id_q    <= sel_idx;
              gnt_valid_q <= 1'b1;
              hold_q      <= '0;
            end else begin
              state_q     <= IDLE;
              gnt_q       <= '0;
              gnt_id_q    <= '0;
              gnt_valid_q <= 1'b0;
              hold_q      <= '0;
            end
          end else if (HOLD_EN && (hold_q != HOLD_LAST)) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Scoreboard bench for rr_arbiter_16: expected grant owners and run lengths are
// queued as stimulus is applied and compared when each grant run starts/ends.
module tb_rr_arbiter_16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_arbiter_16_if bus ();

  rr_arbiter_16 #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned id;
    int unsigned len;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // len == 0 means the run length is not checked (e.g. cut short by reset)
  task automatic expect_grant(input int unsigned id, input int unsigned len);
    exp_t e;
    e.id  = id;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: samples just after each rising edge, tracks grant runs.
  initial begin : monitor
    bit          run_active;
    int unsigned run_id;
    int unsigned run_len;
    int unsigned run_len_exp;
    exp_t        e;
    run_active  = 1'b0;
    run_id      = 0;
    run_len     = 0;
    run_len_exp = 0;
    forever begin
      @(posedge clk);
      #1;
      if (run_active && (!bus.gnt_valid || 32'(bus.gnt_id) != run_id)) begin
        if (run_len_exp != 0) check_eq($sformatf("run_len_id%0d", run_id), run_len, run_len_exp);
        run_active = 1'b0;
      end
      if (bus.gnt_valid && !run_active) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_extra_grant", 32'(bus.gnt_id), 32'hFFFF_FFFF);
          run_len_exp = 0;
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_gnt_id", 32'(bus.gnt_id), e.id);
          run_len_exp = e.len;
        end
        check_eq("sb_req_at_grant", 32'(bus.req[bus.gnt_id]), 32'd1);
        run_active = 1'b1;
        run_id     = 32'(bus.gnt_id);
        run_len    = 0;
      end
      if (run_active) run_len++;
      check_eq("inv_onehot", 32'(bus.gnt),
               bus.gnt_valid ? (32'd1 << bus.gnt_id) : 32'd0);
      check_eq("inv_valid", 32'(bus.gnt_valid), 32'(|bus.gnt));
    end
  end

  initial begin : driver
    rst     = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    check_eq("rst_valid", 32'(bus.gnt_valid), 32'd0);
    rst = 1'b0;

    // single requester, one-cycle latency
    @(negedge clk);
    expect_grant(0, 1);
    bus.req = 16'h0001;
    @(negedge clk);
    check_eq("t1_gnt", 32'(bus.gnt), 32'h0001);
    check_eq("t1_gnt_id", 32'(bus.gnt_id), 32'd0);
    check_eq("t1_valid", 32'(bus.gnt_valid), 32'd1);
    bus.req = '0;
    @(negedge clk);
    check_eq("t1_idle", 32'(bus.gnt_valid), 32'd0);

    // rotation 0,5,10,15, each released after two cycles
    do_reset();
    for (int unsigned k = 0; k < 4; k++) expect_grant(k * 5, 2);
    bus.req = 16'h8421;
    for (int unsigned k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      bus.req[k * 5] = 1'b0;
    end
    @(negedge clk);
    check_eq("t2_idle_gnt", 32'(bus.gnt), 32'd0);

    // ptr wrapped to 0: bit 0 wins over bit 7, then handoff to 7
    expect_grant(0, 1);
    expect_grant(7, 1);
    bus.req = 16'h0081;
    @(negedge clk);
    bus.req = 16'h0080;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);

    // move ptr to 15 via grant 14, then 15 -> 0 wrap without a bubble
    expect_grant(14, 1);
    bus.req = 16'h4000;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    expect_grant(15, 2);
    expect_grant(0, 1);
    bus.req = 16'h8001;
    @(negedge clk);
    check_eq("t3_gnt_id15", 32'(bus.gnt_id), 32'd15);
    @(negedge clk);
    bus.req = 16'h0001;
    @(negedge clk);
    check_eq("t3_gnt_id0", 32'(bus.gnt_id), 32'd0);
    bus.req = '0;
    @(negedge clk);
    check_eq("t3_idle", 32'(bus.gnt_valid), 32'd0);

    // hold-time preemption between two constant requesters
    do_reset();
    expect_grant(0, 8);
    expect_grant(1, 8);
    expect_grant(0, 3);
    bus.req = 16'h0003;
    repeat (19) @(negedge clk);
    bus.req = '0;
    @(negedge clk);

    // sole requester is never preempted
    expect_grant(4, 20);
    bus.req = 16'h0010;
    repeat (20) @(negedge clk);
    bus.req = '0;
    @(negedge clk);

    // asynchronous reset mid-grant
    expect_grant(8, 0);
    bus.req = 16'h0300;
    repeat (3) @(negedge clk);
    check_eq("t6_pre_rst_valid", 32'(bus.gnt_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_gnt", 32'(bus.gnt), 32'd0);
    check_eq("t6_async_valid", 32'(bus.gnt_valid), 32'd0);
    check_eq("t6_async_gnt_id", 32'(bus.gnt_id), 32'd0);
    repeat (2) @(negedge clk);
    expect_grant(8, 2);
    bus.req = 16'h0100;
    rst     = 1'b0;
    @(negedge clk);
    check_eq("t6_gnt_id8", 32'(bus.gnt_id), 32'd8);
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);

    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
